// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
//
// Writer-side companion to the fetch stage's instruction memory. It accepts
// full instruction words over a valid/ready handshake and writes each one as
// a sequence of byte-wide stores, most significant byte first, at ascending
// byte addresses. The program counter is held in reset while a load is in
// progress. When the load ends, the PC is released so that fetch starts at
// address 0.
//
// Optional feature: define LOADER_CHECKSUM_EN to build a running XOR of every
// byte written since the last i_start. Without the macro, o_checksum is tied
// to 0 and no checksum register is built.
//
// Parameters:
//   INSTRUCTION_SIZE  width of one instruction word (multiple of MEM_SIZE)
//   MEM_SIZE          width of one memory byte lane
//   INSTMEM_SIZE      byte address width
//
// Ports:
//   i_clock         clock, rising edge
//   i_reset         synchronous active-high reset
//   i_start         pulse, begins a new load from address 0
//   i_valid         i_word is valid
//   i_word          instruction word to store
//   i_last          marks i_word as the final word of the program
//   o_ready         loader accepts i_word this cycle
//   o_mem_enable    instruction memory enable
//   o_write_enable  instruction memory write enable
//   o_write_data    byte being written
//   o_write_addr    byte address (also the running address counter)
//   o_pc_reset      high while a load is in progress
//   o_done          load finished, held until the next i_start
//   o_overflow      memory filled before the last word was seen
//   o_checksum      XOR of written bytes (0 when the feature is off)
// ---------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int INSTRUCTION_SIZE = 32,
    parameter int MEM_SIZE         = 8,
    parameter int INSTMEM_SIZE     = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_valid,
    input  logic [INSTRUCTION_SIZE-1:0] i_word,
    input  logic                        i_last,
    output logic                        o_ready,
    output logic                        o_mem_enable,
    output logic                        o_write_enable,
    output logic [MEM_SIZE-1:0]         o_write_data,
    output logic [INSTMEM_SIZE-1:0]     o_write_addr,
    output logic                        o_pc_reset,
    output logic                        o_done,
    output logic                        o_overflow,
    output logic [MEM_SIZE-1:0]         o_checksum
);

    localparam int BYTES = INSTRUCTION_SIZE / MEM_SIZE;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(BYTES - 1);
    localparam logic [INSTMEM_SIZE-1:0] ADDR_TOP = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                      state, state_d;
    logic [INSTRUCTION_SIZE-1:0] word_q, word_d;
    logic                        last_q, last_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [MEM_SIZE-1:0]         data_d;
    logic [INSTMEM_SIZE-1:0]     addr_d;
    logic                        overflow_d;
    logic                        clear_d;

    always_comb begin
        state_d    = state;
        word_d     = word_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        data_d     = o_write_data;
        addr_d     = o_write_addr;
        overflow_d = o_overflow;
        clear_d    = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    state_d    = LOAD;
                    addr_d     = '0;
                    overflow_d = 1'b0;
                    clear_d    = 1'b1;
                end
            end
            LOAD: begin
                // o_ready is registered high for the whole LOAD state
                if (i_valid) begin
                    state_d = WRITE;
                    data_d  = i_word[INSTRUCTION_SIZE-1 -: MEM_SIZE];
                    word_d  = i_word << MEM_SIZE;
                    last_d  = i_last;
                    cnt_d   = '0;
                end
            end
            WRITE: begin
                addr_d = o_write_addr + 1'b1;
                if (cnt_q == CNT_LAST && last_q) begin
                    // last byte of the program may land on the top address
                    state_d = DONE;
                end else if (o_write_addr == ADDR_TOP) begin
                    state_d    = DONE;
                    overflow_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOAD;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    data_d = word_q[INSTRUCTION_SIZE-1 -: MEM_SIZE];
                    word_d = word_q << MEM_SIZE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state          <= IDLE;
            word_q         <= '0;
            last_q         <= 1'b0;
            cnt_q          <= '0;
            o_ready        <= 1'b0;
            o_mem_enable   <= 1'b0;
            o_write_enable <= 1'b0;
            o_write_data   <= '0;
            o_write_addr   <= '0;
            o_pc_reset     <= 1'b0;
            o_done         <= 1'b0;
            o_overflow     <= 1'b0;
        end else begin
            state          <= state_d;
            word_q         <= word_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            o_ready        <= (state_d == LOAD);
            o_mem_enable   <= (state_d == LOAD) || (state_d == WRITE);
            o_write_enable <= (state_d == WRITE);
            o_write_data   <= data_d;
            o_write_addr   <= addr_d;
            o_pc_reset     <= (state_d == LOAD) || (state_d == WRITE);
            o_done         <= (state_d == DONE);
            o_overflow     <= overflow_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [MEM_SIZE-1:0] checksum_q;

    // folds in the byte on the strobe, so the sum is visible the cycle after
    always_ff @(posedge i_clock) begin
        if (i_reset || clear_d) begin
            checksum_q <= '0;
        end else if (state == WRITE) begin
            checksum_q <= checksum_q ^ o_write_data;
        end
    end

    assign o_checksum = checksum_q;
`else
    logic unused_clear;
    assign unused_clear = clear_d;
    assign o_checksum   = '0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic        i_valid;
    logic [31:0] i_word;
    logic        i_last;
    logic        o_ready;
    logic        o_mem_enable;
    logic        o_write_enable;
    logic [7:0]  o_write_data;
    logic [7:0]  o_write_addr;
    logic        o_pc_reset;
    logic        o_done;
    logic        o_overflow;
    logic [7:0]  o_checksum;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  m_addr;
    logic [7:0]  m_csum;

    always #5 clk = ~clk;

    inst_mem_loader #(
        .INSTRUCTION_SIZE(32),
        .MEM_SIZE(8),
        .INSTMEM_SIZE(8)
    ) dut (
        .i_clock(clk),
        .i_reset(i_reset),
        .i_start(i_start),
        .i_valid(i_valid),
        .i_word(i_word),
        .i_last(i_last),
        .o_ready(o_ready),
        .o_mem_enable(o_mem_enable),
        .o_write_enable(o_write_enable),
        .o_write_data(o_write_data),
        .o_write_addr(o_write_addr),
        .o_pc_reset(o_pc_reset),
        .o_done(o_done),
        .o_overflow(o_overflow),
        .o_checksum(o_checksum)
    );

    // scoreboard pop side: every write strobe must match the next expected byte
    always @(negedge clk) begin
        logic [15:0] e;
        if (o_write_enable === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: got addr=%02h data=%02h, required no strobe",
                         o_write_addr, o_write_data);
            end else begin
                e = exp_q.pop_front();
                if ({o_write_addr, o_write_data} !== e) begin
                    n_fail++;
                    $display("FAIL write_byte: got addr=%02h data=%02h, required addr=%02h data=%02h",
                             o_write_addr, o_write_data, e[15:8], e[7:0]);
                end
            end
            n_checks++;
            if (o_pc_reset !== 1'b1 || o_mem_enable !== 1'b1 || o_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL write_ctrl: got pc_reset=%b mem_enable=%b ready=%b, required 1 1 0",
                         o_pc_reset, o_mem_enable, o_ready);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [31:0] w);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = w[31-8*k -: 8];
            exp_q.push_back({m_addr, b});
            m_csum = m_csum ^ b;
            m_addr = m_addr + 8'd1;
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        m_addr = 8'd0;
        m_csum = 8'd0;
    endtask

    // called and returns at a negedge; leaves the DUT at ready or done
    task automatic send_word(input logic [31:0] w, input logic last,
                             input logic hold_valid, input logic chk_gap);
        int t;
        i_valid = 1'b1;
        i_word  = w;
        i_last  = last;
        t = 0;
        while (o_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: o_ready=%b after 50 cycles, required 1", o_ready);
            i_valid = 1'b0;
            return;
        end
        push_word(w);
        @(negedge clk);
        if (!hold_valid) i_valid = 1'b0;
        t = 0;
        while (o_ready !== 1'b1 && o_done !== 1'b1 && t < 20) begin
            t++;
            @(negedge clk);
        end
        if (chk_gap) begin
            n_checks++;
            if (t != 4) begin
                n_fail++;
                $display("FAIL ready_gap: got %0d busy cycles, required 4", t);
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_start = 1'b0;
        i_valid = 1'b0;
        i_word  = 32'h0;
        i_last  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_ready, o_mem_enable, o_write_enable, o_pc_reset, o_done, o_overflow} !== 6'b0 ||
            o_write_data !== 8'h00 || o_write_addr !== 8'h00 || o_checksum !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b men=%b we=%b pcr=%b done=%b ovf=%b data=%02h addr=%02h cs=%02h, required all 0",
                     o_ready, o_mem_enable, o_write_enable, o_pc_reset, o_done, o_overflow,
                     o_write_data, o_write_addr, o_checksum);
        end
        i_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (o_ready !== 1'b0 || o_pc_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: got ready=%b pc_reset=%b, required 0 0", o_ready, o_pc_reset);
        end
    endtask

    task automatic test_single_word();
        pulse_start();
        n_checks++;
        if (o_ready !== 1'b1 || o_pc_reset !== 1'b1 || o_mem_enable !== 1'b1 || o_write_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL start_load: got ready=%b pcr=%b men=%b addr=%02h, required 1 1 1 00",
                     o_ready, o_pc_reset, o_mem_enable, o_write_addr);
        end
        send_word(32'h8C220004, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (o_done !== 1'b1 || o_pc_reset !== 1'b0 || o_mem_enable !== 1'b0 ||
            o_overflow !== 1'b0 || o_write_addr !== 8'd4) begin
            n_fail++;
            $display("FAIL single_done: got done=%b pcr=%b men=%b ovf=%b addr=%02h, required 1 0 0 0 04",
                     o_done, o_pc_reset, o_mem_enable, o_overflow, o_write_addr);
        end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        send_word(32'hA1B2C3D4, 1'b0, 1'b1, 1'b1);
        send_word(32'h0F1E2D3C, 1'b0, 1'b1, 1'b1);
        send_word(32'h55AA33CC, 1'b1, 1'b1, 1'b1);
        i_valid = 1'b0;
        n_checks++;
        if (o_done !== 1'b1 || o_write_addr !== 8'd12 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_end: got done=%b addr=%0d pending=%0d, required 1 12 0",
                     o_done, o_write_addr, exp_q.size());
        end
    endtask

    task automatic test_fill(input logic with_last);
        logic [31:0] w;
        pulse_start();
        for (int i = 1; i <= 64; i++) begin
            w = {8'(i), 8'(i) ^ 8'hA5, ~8'(i), 8'(i * 3)};
            send_word(w, with_last && (i == 64), 1'b0, 1'b1);
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (o_done !== 1'b1 || o_overflow !== !with_last || o_pc_reset !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL fill_end(last=%b): got done=%b ovf=%b pcr=%b pending=%0d, required 1 %b 0 0",
                     with_last, o_done, o_overflow, o_pc_reset, exp_q.size(), !with_last);
        end
    endtask

    task automatic test_overflow_stops();
        logic [31:0] w;
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            w = 32'h01010101 * i;
            send_word(w, 1'b0, 1'b0, 1'b0);
        end
        // further valid words must not cause strobes once overflowed
        i_valid = 1'b1;
        i_word  = 32'hFFFFFFFF;
        repeat (10) @(negedge clk);
        i_valid = 1'b0;
        n_checks++;
        if (o_overflow !== 1'b1 || o_ready !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL overflow_hold: got ovf=%b ready=%b pending=%0d, required 1 0 0",
                     o_overflow, o_ready, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_write();
        pulse_start();
        i_valid = 1'b1;
        i_word  = 32'hDEADBEEF;
        i_last  = 1'b0;
        push_word(32'hDEADBEEF);
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        n_checks++;
        if ({o_ready, o_mem_enable, o_write_enable, o_pc_reset, o_done, o_overflow} !== 6'b0 ||
            o_write_data !== 8'h00 || o_write_addr !== 8'h00 || o_checksum !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_write: got rdy=%b men=%b we=%b pcr=%b done=%b ovf=%b data=%02h addr=%02h cs=%02h, required all 0",
                     o_ready, o_mem_enable, o_write_enable, o_pc_reset, o_done, o_overflow,
                     o_write_data, o_write_addr, o_checksum);
        end
        i_reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_ready !== 1'b0 || o_write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_to_idle: got ready=%b we=%b, required 0 0", o_ready, o_write_enable);
        end
        pulse_start();
        send_word(32'h11223344, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (o_done !== 1'b1 || o_write_addr !== 8'd4) begin
            n_fail++;
            $display("FAIL reload_after_reset: got done=%b addr=%0d, required 1 4", o_done, o_write_addr);
        end
    endtask

    task automatic test_start_ignored_and_checksum();
        int t;
        logic [7:0] cs_exp;
        pulse_start();
        i_valid = 1'b1;
        i_word  = 32'hCAFEF00D;
        i_last  = 1'b0;
        push_word(32'hCAFEF00D);
        @(negedge clk);
        i_valid = 1'b0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        t = 0;
        while (o_ready !== 1'b1 && t < 20) begin
            t++;
            @(negedge clk);
        end
        n_checks++;
        if (o_ready !== 1'b1 || o_write_addr !== 8'd4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL start_in_write: got ready=%b addr=%0d pending=%0d, required 1 4 0",
                     o_ready, o_write_addr, exp_q.size());
        end
        send_word(32'h0BADF00D, 1'b1, 1'b0, 1'b1);
        // restart from DONE
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        m_addr = 8'd0;
        m_csum = 8'd0;
        n_checks++;
        if (o_done !== 1'b0 || o_write_addr !== 8'd0 || o_ready !== 1'b1 ||
            o_overflow !== 1'b0 || o_checksum !== 8'h00) begin
            n_fail++;
            $display("FAIL start_in_done: got done=%b addr=%0d ready=%b ovf=%b cs=%02h, required 0 0 1 0 00",
                     o_done, o_write_addr, o_ready, o_overflow, o_checksum);
        end
        send_word(32'h01020304, 1'b0, 1'b0, 1'b1);
        send_word(32'h10203040, 1'b1, 1'b0, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        cs_exp = m_csum;
`else
        cs_exp = 8'h00;
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_done !== 1'b1 || o_checksum !== cs_exp) begin
            n_fail++;
            $display("FAIL checksum: got done=%b cs=%02h, required 1 %02h", o_done, o_checksum, cs_exp);
        end
    endtask

    initial begin
        m_addr = 8'd0;
        m_csum = 8'd0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_fill(1'b0);
        test_fill(1'b1);
        test_overflow_stops();
        test_reset_mid_write();
        test_start_ignored_and_checksum();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Writer-side companion to the fetch stage's instruction memory: accepts full instruction words from the debug/load path over a valid/ready handshake. Each word is serialised into byte-wide writes on the memory's write port (enable, write enable, byte data, byte address). While a load is in progress the block holds the program counter in reset; afterwards it releases the PC so fetch starts at address 0.

## Interface
Parameters:
- INSTRUCTION_SIZE, 32, width of one instruction word; must be a multiple of MEM_SIZE
- MEM_SIZE, 8, width of one memory byte lane (write data width)
- INSTMEM_SIZE, 8, byte address width; memory holds 2^INSTMEM_SIZE bytes

Ports:
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  pulse; begins a new load, clears address
- i_valid  in  1  i_word is valid
- i_word  in  INSTRUCTION_SIZE  instruction to store
- i_last  in  1  qualifies i_word as final instruction of the program
- o_ready  out  1  loader can accept i_word this cycle
- o_mem_enable  out  1  instruction memory enable
- o_write_enable  out  1  instruction memory write enable
- o_write_data  out  MEM_SIZE  byte to write
- o_write_addr  out  INSTMEM_SIZE  byte address
- o_pc_reset  out  1  held high while loading
- o_done  out  1  load finished; level until next i_start
- o_overflow  out  1  memory filled before i_last seen
- o_checksum  out  MEM_SIZE  running XOR of written bytes (see Configuration)

## Operation
- BYTES = INSTRUCTION_SIZE/MEM_SIZE (4 by default).
- States: IDLE, LOAD, WRITE, DONE.
  - IDLE: o_ready=0, o_pc_reset=0. i_start -> LOAD, addr<=0, overflow<=0, checksum<=0.
  - LOAD: o_ready=1, o_pc_reset=1. i_valid&o_ready -> latch word, latch i_last, byte counter<=0, go to WRITE.
  - WRITE: o_ready=0. One byte written per cycle, big-endian: byte k = i_word[INSTRUCTION_SIZE-1-k*MEM_SIZE -: MEM_SIZE], at addr+k. The address counter increments after every byte. After byte BYTES-1: latched last -> DONE; else -> LOAD.
  - DONE: o_done=1, o_pc_reset=0, o_mem_enable=0. i_start -> LOAD (restart as from IDLE).
- Address arithmetic is modulo 2^INSTMEM_SIZE. If the byte at address 2^INSTMEM_SIZE-1 is written and it is not the final byte of a last-marked word: o_overflow<=1, go to DONE; no further writes. A last word whose final byte lands at the top address completes normally, overflow=0.
- i_start is ignored in LOAD and WRITE. i_valid is ignored outside LOAD.
- o_mem_enable=1 in LOAD and WRITE; o_write_enable=1 only in WRITE.

## Timing
- All outputs are registered. Reset values: o_ready=0, o_mem_enable=0, o_write_enable=0, o_write_data=0, o_write_addr=0, o_pc_reset=0, o_done=0, o_overflow=0, o_checksum=0; state=IDLE.
- i_start sampled at edge N: o_ready=1 and o_pc_reset=1 from cycle N+1.
- Handshake at edge M: write strobes for bytes 0..BYTES-1 in cycles M+1..M+BYTES, with o_ready=0 throughout. o_ready returns at M+BYTES+1, or o_done is asserted instead.
- Throughput: one word per BYTES+1 cycles.
- i_valid may stay high across cycles; a word is consumed only on a valid&ready edge.
- Reset mid-WRITE: the write strobe drops at the next edge, the partial word is abandoned, and the address returns to 0.

## Configuration
- LOADER_CHECKSUM_EN defined: o_checksum holds the XOR of every byte written since the last i_start, updated in the cycle after each write strobe, and is stable in DONE.
- Undefined: o_checksum is tied to 0 and no checksum register is built.

## Test plan
- Reset then i_start, single word 0x8C220004 with i_last: writes 0x8C@0, 0x22@1, 0x00@2, 0x04@3 on consecutive cycles; o_done=1 next; o_pc_reset 1 from start until done.
- Three words, i_last on the third, with i_valid held high throughout: addresses 0..11 written in order; o_ready low for 4 cycles after each accept; final addr counter=12.
- Fill: 64 words with no i_last: the last write is to address 255, then o_overflow=1, o_done=1, and there are no further strobes. Repeat with i_last on word 64: overflow=0.
- Reset asserted in the 2nd byte cycle of a word: next cycle o_write_enable=0, state IDLE, all outputs at reset values. A new i_start reloads from address 0.
- i_start pulsed during WRITE has no effect. i_start in DONE: done clears and addr=0. With LOADER_CHECKSUM_EN, words 0x01020304 and 0x10203040 give o_checksum=0x44.
